// File: rtl/issue_dispatch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ooo_pkg
// Brief    : Shared types and helpers for the dispatch steering logic.
// Revision : 1.0 - initial release
// ============================================================================
package ooo_pkg;

    localparam int UNIT_ALU = 0;
    localparam int UNIT_FPU = 1;
    localparam int UNIT_LSU = 2;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } hold_state_e;

    // One extra bit so a full station (credit == RS_DEPTH) is representable.
    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unit_idx_width(input int num_units);
        return (num_units > 1) ? $clog2(num_units) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_dispatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : issue_dispatch_ctrl_if
// Brief    : Decode-side, RS-side and monitor signals of the dispatch steering.
// Revision : 1.0 - initial release
// ============================================================================
interface issue_dispatch_ctrl_if #(
    parameter int NUM_UNITS = 3,
    parameter int RS_DEPTH  = 4,
    parameter int PAYLOAD_W = 96,
    parameter int CNT_W     = 32
);
    import ooo_pkg::*;

    localparam int UNIT_W = unit_idx_width(NUM_UNITS);
    localparam int CRED_W = credit_width(RS_DEPTH);

    logic                        in_valid;
    logic [UNIT_W-1:0]           in_unit;
    logic [PAYLOAD_W-1:0]        in_payload;
    logic                        in_ready;
    logic                        stall_pipeline;
    logic                        flush_pipeline;
    logic                        sb_can_issue;
    logic [NUM_UNITS-1:0]        rs_release;
    logic [NUM_UNITS-1:0]        disp_en;
    logic [PAYLOAD_W-1:0]        disp_payload;
    logic                        issue_stall;
    logic [NUM_UNITS*CRED_W-1:0] credits;
    logic [NUM_UNITS*CNT_W-1:0]  stall_cycles;
    logic                        credit_err;
    logic                        unit_err;

    modport master (
        output in_valid, in_unit, in_payload, stall_pipeline, flush_pipeline,
               sb_can_issue, rs_release,
        input  in_ready, disp_en, disp_payload, issue_stall, credits,
               stall_cycles, credit_err, unit_err
    );

    modport slave (
        input  in_valid, in_unit, in_payload, stall_pipeline, flush_pipeline,
               sb_can_issue, rs_release,
        output in_ready, disp_en, disp_payload, issue_stall, credits,
               stall_cycles, credit_err, unit_err
    );

endinterface
`default_nettype wire

// File: rtl/issue_dispatch_ctrl_credit.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_credit_counter
// Brief    : One reservation station's credit counter and saturating stall count.
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_credit_counter
    import ooo_pkg::*;
#(
    parameter int RS_DEPTH = 4,
    parameter int CNT_W    = 32
) (
    input  wire logic                              clk,
    input  wire logic                              rst_n,
    input  wire logic                              flush_i,
    input  wire logic                              fire_i,
    input  wire logic                              release_i,
    input  wire logic                              stall_i,
    output logic [credit_width(RS_DEPTH)-1:0]      credit_o,
    output logic [CNT_W-1:0]                       stall_cnt_o,
    output logic                                   credit_ovf_o
);

    localparam int                CRED_W   = credit_width(RS_DEPTH);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RS_DEPTH);

    logic [CRED_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    always_comb begin
        credit_d     = credit_q;
        credit_ovf_o = 1'b0;
        // The station empties along with the pipeline, so the release is moot.
        if (flush_i) begin
            credit_d = CRED_MAX;
        end else if (fire_i && !release_i) begin
            if (credit_q != '0) begin
                credit_d = credit_q - CRED_W'(1);
            end
        end else if (release_i && !fire_i) begin
            if (credit_q == CRED_MAX) begin
                credit_ovf_o = 1'b1;
            end else begin
                credit_d = credit_q + CRED_W'(1);
            end
        end

        stall_d = stall_q;
        if (stall_i && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_q <= CRED_MAX;
            stall_q  <= '0;
        end else begin
            credit_q <= credit_d;
            stall_q  <= stall_d;
        end
    end

    assign credit_o    = credit_q;
    assign stall_cnt_o = stall_q;

endmodule
`default_nettype wire

// File: rtl/issue_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : issue_dispatch_ctrl
// Brief    : Single-entry hold register steering decoded instructions to RSs.
// Revision : 1.0 - initial release
// ============================================================================
module issue_dispatch_ctrl
    import ooo_pkg::*;
#(
    parameter int NUM_UNITS = 3,
    parameter int RS_DEPTH  = 4,
    parameter int PAYLOAD_W = 96,
    parameter int CNT_W     = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    issue_dispatch_ctrl_if.slave  disp_if
);

    localparam int UNIT_W = unit_idx_width(NUM_UNITS);
    localparam int CRED_W = credit_width(RS_DEPTH);

    hold_state_e          state_q, state_d;
    logic [UNIT_W-1:0]    unit_q, unit_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 credit_err_q, credit_err_d;
    logic                 unit_err_q, unit_err_d;

    logic [CRED_W-1:0]    credit [NUM_UNITS];
    logic [CNT_W-1:0]     stall_cnt [NUM_UNITS];
    logic [NUM_UNITS-1:0] fire_vec;
    logic [NUM_UNITS-1:0] stall_vec;
    logic [NUM_UNITS-1:0] ovf_vec;
    logic [NUM_UNITS-1:0] cred_ok;

    logic held;
    logic fire;
    logic ready;
    logic accept;
    logic unit_legal;
    logic flush;

    assign flush      = disp_if.flush_pipeline;
    assign held       = (state_q == ST_HELD);
    assign unit_legal = 32'(disp_if.in_unit) < 32'(NUM_UNITS);

    // Gated by rst_n so a held instruction cannot strobe out during reset.
    assign fire   = held && rst_n && !disp_if.stall_pipeline && !flush
                    && disp_if.sb_can_issue && cred_ok[unit_q];
    assign ready  = (!held || fire) && !flush;
    assign accept = disp_if.in_valid && ready;

    always_comb begin
        state_d      = state_q;
        unit_d       = unit_q;
        payload_d    = payload_q;
        credit_err_d = credit_err_q | (|ovf_vec);
        unit_err_d   = unit_err_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            if (fire) begin
                state_d = ST_EMPTY;
            end
            if (accept) begin
                if (unit_legal) begin
                    state_d   = ST_HELD;
                    unit_d    = disp_if.in_unit;
                    payload_d = disp_if.in_payload;
                end else begin
                    unit_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            unit_q       <= '0;
            payload_q    <= '0;
            credit_err_q <= 1'b0;
            unit_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            unit_q       <= unit_d;
            payload_q    <= payload_d;
            credit_err_q <= credit_err_d;
            unit_err_q   <= unit_err_d;
        end
    end

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
        assign fire_vec[g]  = fire && (unit_q == UNIT_W'(g));
        assign stall_vec[g] = held && (unit_q == UNIT_W'(g)) && !fire && !flush;
        assign cred_ok[g]   = (credit[g] != '0);

        dispatch_credit_counter #(
            .RS_DEPTH (RS_DEPTH),
            .CNT_W    (CNT_W)
        ) u_credit (
            .clk          (clk),
            .rst_n        (rst_n),
            .flush_i      (flush),
            .fire_i       (fire_vec[g]),
            .release_i    (disp_if.rs_release[g]),
            .stall_i      (stall_vec[g]),
            .credit_o     (credit[g]),
            .stall_cnt_o  (stall_cnt[g]),
            .credit_ovf_o (ovf_vec[g])
        );

        assign disp_if.credits[g*CRED_W +: CRED_W]     = credit[g];
        assign disp_if.stall_cycles[g*CNT_W +: CNT_W]  = stall_cnt[g];
    end

    assign disp_if.in_ready     = ready;
    assign disp_if.disp_en      = fire_vec;
    assign disp_if.disp_payload = payload_q;
    assign disp_if.issue_stall  = held && !fire && !flush;
    assign disp_if.credit_err   = credit_err_q;
    assign disp_if.unit_err     = unit_err_q;

endmodule
`default_nettype wire
